// File: rtl/sram_burst_controller.sv
// sram_burst_controller: single-request bridge from the MEM stage to an
// asynchronous SRAM. Reads fetch an aligned line as consecutive SRAM beats.
// Writes store one CPU word. The pipeline is stalled through readyOut.
module sram_burst_controller #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned SRAM_DW     = 16,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned LINE_WORDS  = 2,
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wrEnIn,
    input  logic                           rdEnIn,
    input  logic [31:0]                    addressIn,
    input  logic [WORD_W-1:0]              writeDataIn,
    output logic [LINE_WORDS*WORD_W-1:0]   readDataOut,
    output logic                           readyOut,
    inout  wire  [SRAM_DW-1:0]             SRAM_DQInOut,
    output logic [SRAM_AW-1:0]             SRAM_ADDROut,
    output logic                           SRAM_UB_NOut,
    output logic                           SRAM_LB_NOut,
    output logic                           SRAM_WE_NOut,
    output logic                           SRAM_CE_NOut,
    output logic                           SRAM_OE_NOut
);

    localparam int unsigned H        = WORD_W / SRAM_DW;
    localparam int unsigned NR       = LINE_WORDS * H;
    localparam int unsigned NW       = H;
    localparam int unsigned LINE_W   = LINE_WORDS * WORD_W;
    localparam int unsigned BYTE_SH  = $clog2(WORD_W / 8);
    localparam int unsigned BEAT_W   = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned WAIT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic [BEAT_W-1:0]   r_beat;
    logic [SRAM_AW-1:0]  r_base;
    logic [WORD_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_line;

    logic [31:0]         w_mem_addr;
    logic [31:0]         w_word_idx;
    logic [SRAM_AW-1:0]  w_rd_base;
    logic [SRAM_AW-1:0]  w_wr_base;
    logic [31:0]         w_shift;
    logic [BEAT_W-1:0]   w_last_beat;
    logic                w_beat_end;
    logic                w_busy;
    logic [SRAM_DW-1:0]  w_dq_out;
    logic [LINE_W-1:0]   w_line_next;

    // Beat base addresses from the CPU byte address (all arithmetic wraps)
    assign w_mem_addr = addressIn - 32'(ADDR_BASE);
    assign w_word_idx = w_mem_addr >> BYTE_SH;
    assign w_rd_base  = SRAM_AW'((w_word_idx & ~32'(LINE_WORDS - 1)) * 32'(H));
    assign w_wr_base  = SRAM_AW'(w_word_idx * 32'(H));

    // Beat bookkeeping
    assign w_shift     = 32'(r_beat) * 32'(SRAM_DW);
    assign w_last_beat = (r_state == S_READ) ? BEAT_W'(NR - 1) : BEAT_W'(NW - 1);
    assign w_beat_end  = (r_wait == WAIT_W'(WAIT_CYCLES));
    assign w_busy      = (r_state == S_READ) || (r_state == S_WRITE);

    // Line buffer with the current beat's slot replaced by the bus value
    always_comb begin
        w_line_next = r_line;
        w_line_next = (w_line_next & ~(LINE_W'({SRAM_DW{1'b1}}) << w_shift))
                    | (LINE_W'(SRAM_DQInOut) << w_shift);
    end

    // SRAM strobes and address decoded from registered state only
    assign w_dq_out     = SRAM_DW'(r_wdata >> w_shift);
    assign SRAM_DQInOut = (r_state == S_WRITE) ? w_dq_out : {SRAM_DW{1'bz}};
    assign SRAM_ADDROut = w_busy ? SRAM_AW'(r_base + SRAM_AW'(r_beat)) : '0;
    assign SRAM_CE_NOut = ~w_busy;
    assign SRAM_OE_NOut = (r_state != S_READ);
    assign SRAM_WE_NOut = (r_state != S_WRITE);
    assign SRAM_UB_NOut = 1'b0;
    assign SRAM_LB_NOut = 1'b0;

    // Stall: in IDLE the request itself holds the pipeline; DONE releases it
    assign readyOut = (r_state == S_IDLE) ? ~(rdEnIn | wrEnIn) : (r_state == S_DONE);

    // Request acceptance, beat sequencing and line capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_beat      <= '0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_line      <= '0;
            readDataOut <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    r_beat <= '0;
                    if (rdEnIn) begin
                        r_state <= S_READ;
                        r_base  <= w_rd_base;
                    end else if (wrEnIn) begin
                        r_state <= S_WRITE;
                        r_base  <= w_wr_base;
                        r_wdata <= writeDataIn;
                    end
                end
                S_READ, S_WRITE: begin
                    if (w_beat_end) begin
                        r_wait <= '0;
                        if (r_state == S_READ) begin
                            r_line <= w_line_next;
                        end
                        if (r_beat == w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= S_DONE;
                            if (r_state == S_READ) begin
                                readDataOut <= w_line_next;
                            end
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
